// File: rtl/key_schedule_seq.sv
// key_schedule_seq: sequential AES-128/192/256 key expansion emitting round keys over valid/ready
module key_schedule_seq #(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [MAX_KEY_BITS-1:0] key,
  input  logic [1:0]              key_len,
  output logic [127:0]            round_key,
  output logic [3:0]              round_idx,
  output logic                    rk_valid,
  input  logic                    rk_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;
  state_t state;
  logic [255:0] kreg;
  logic [7:0][31:0] win;
  logic [31:0] slot [3];
  logic [5:0] i;
  logic [2:0] m, nkm;
  logic [3:0] nr;
  logic [7:0] rcon;
  logic legal, stall, hs, expand, last;
  logic [31:0] prev, lag, sw_in, sw, wi;
  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[{~x, 3'b111} -: 8];
  endfunction
  assign legal = key_len != 2'd3 && 128 + 64 * int'(key_len) <= MAX_KEY_BITS;
  assign stall = rk_valid && !rk_ready;
  assign hs = rk_valid && rk_ready;
  assign expand = i > {3'b0, nkm};
  assign last = i == {nr, 2'b11};
  assign prev = win[0];
  assign lag = win[nkm];
  assign sw_in = m == 3'd0 ? {prev[23:0], prev[31:24]} : prev;
  assign sw = {sb(sw_in[31:24]), sb(sw_in[23:16]), sb(sw_in[15:8]), sb(sw_in[7:0])};
  assign wi = !expand ? kreg[255:224] :
              m == 3'd0 ? lag ^ sw ^ {rcon, 24'h0} :
              nkm == 3'd7 && m == 3'd4 ? lag ^ sw : lag ^ prev;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      round_key <= '0;
      round_idx <= '0;
      rk_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      i <= '0;
      m <= '0;
      rcon <= 8'h01;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      if (hs) rk_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (legal) begin
            kreg <= 256'(key) << (256 - MAX_KEY_BITS);
            nkm <= 3'd3 + {key_len, 1'b0};
            nr <= 4'd10 + {1'b0, key_len, 1'b0};
            i <= '0;
            m <= '0;
            rcon <= 8'h01;
            busy <= 1'b1;
            state <= GEN;
          end else err <= 1'b1;
        end
        GEN: if (!stall) begin
          kreg <= kreg << 32;
          win <= {win[6:0], wi};
          i <= i + 6'd1;
          m <= m == nkm ? 3'd0 : m + 3'd1;
          if (expand && m == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          if (i[1:0] == 2'd3) begin
            round_key <= {slot[0], slot[1], slot[2], wi};
            round_idx <= i[5:2];
            rk_valid <= 1'b1;
          end else slot[i[1:0]] <= wi;
          if (last) state <= DRAIN;
        end
        DRAIN: if (hs) begin
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_key_schedule_seq.sv
// tb_key_schedule_seq: model-checked directed test of the sequential AES key schedule
module tb_key_schedule_seq;
  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, start, rk_ready, rk_valid, busy, done, err;
  logic [255:0] key;
  logic [1:0] key_len;
  logic [127:0] round_key;
  logic [3:0] round_idx;
  logic start_s, rk_valid_s, busy_s, done_s, err_s;
  logic [127:0] key_s, round_key_s;
  logic [1:0] key_len_s;
  logic [3:0] round_idx_s;
  int checks = 0, errors = 0, hs_cnt = 0, exp_nr = 10, edge_no = 0, e0 = 0;
  bit chk_en = 1'b0, pend_done = 1'b0;
  int vt [16];
  int stalled [16];
  logic [15:0] smask = '0;
  logic [7:0] sbt [256];
  logic [31:0] exp_w [60];
  logic [127:0] exp_rk [15];

  key_schedule_seq #(.MAX_KEY_BITS(256)) dut (
    .clk(clk), .reset(reset), .start(start), .key(key), .key_len(key_len),
    .round_key(round_key), .round_idx(round_idx), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .busy(busy), .done(done), .err(err));

  key_schedule_seq #(.MAX_KEY_BITS(128)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .key(key_s), .key_len(key_len_s),
    .round_key(round_key_s), .round_idx(round_idx_s), .rk_valid(rk_valid_s), .rk_ready(1'b1),
    .busy(busy_s), .done(done_s), .err(err_s));

  always @(posedge clk) edge_no <= edge_no + 1;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbt[x[31:24]], sbt[x[23:16]], sbt[x[15:8]], sbt[x[7:0]]};
  endfunction

  task automatic build(input logic [255:0] k, input int len);
    int nk;
    logic [7:0] rc;
    logic [31:0] t;
    nk = 4 + 2 * len;
    exp_nr = 10 + 2 * len;
    rc = 8'h01;
    for (int j = 0; j < 4 * (exp_nr + 1); j++) begin
      if (j < nk) exp_w[j] = k[255 - 32 * j -: 32];
      else begin
        t = exp_w[j - 1];
        if (j % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk == 8 && j % 8 == 4) t = subw(t);
        exp_w[j] = exp_w[j - nk] ^ t;
      end
    end
    for (int r = 0; r <= exp_nr; r++)
      exp_rk[r] = {exp_w[4 * r], exp_w[4 * r + 1], exp_w[4 * r + 2], exp_w[4 * r + 3]};
  endtask

  task automatic prep(input logic [255:0] k, input logic [1:0] kl);
    build(k, int'(kl));
    hs_cnt = 0;
    pend_done = 1'b0;
    for (int r = 0; r < 16; r++) begin
      vt[r] = -1;
      stalled[r] = 0;
    end
    chk_en = 1'b1;
  endtask

  task automatic run(input logic [255:0] k, input logic [1:0] kl, input int poke, input int exp_done);
    int cyc;
    prep(k, kl);
    key = k;
    key_len = kl;
    start = 1'b1;
    @(posedge clk); #1;
    e0 = edge_no;
    start = 1'b0;
    key = ~k;
    key_len = 2'd3;
    cyc = 0;
    chk("busy_on", busy, 1);
    while (!done && cyc < exp_done + 20) begin
      start = cyc == poke;
      @(posedge clk); #1;
      cyc++;
      chk("no_err_while_busy", err, 0);
    end
    start = 1'b0;
    chk("done_cycle", cyc, exp_done);
    chk("busy_off", busy, 0);
    chk("key_count", hs_cnt, exp_nr + 1);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    rk_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rk_valid && smask[round_idx] && stalled[round_idx] < 5) begin
        rk_ready = 1'b0;
        stalled[round_idx]++;
      end else rk_ready = 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("done", done, pend_done);
      pend_done = 1'b0;
      if (rk_valid) begin
        if (hs_cnt > exp_nr) begin
          checks++;
          errors++;
          $display("FAIL extra_key got round_idx %0d expected none after %0d keys", round_idx, hs_cnt);
        end else begin
          if (vt[hs_cnt] < 0) vt[hs_cnt] = edge_no - e0;
          chk("round_key", round_key, exp_rk[hs_cnt]);
          chk("round_idx", round_idx, 128'(hs_cnt));
          if (rk_ready) begin
            pend_done = hs_cnt == exp_nr;
            hs_cnt++;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] b;
    for (int a = 0; a < 256; a++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(a), 8'(y)) == 8'h01) b = 8'(y);
      sbt[a] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
    reset = 1'b1;
    start = 1'b0;
    key = '0;
    key_len = 2'd0;
    start_s = 1'b0;
    key_s = '0;
    key_len_s = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_round_key", round_key, 0);
    chk("rst_round_idx", round_idx, 0);
    chk("rst_rk_valid", rk_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    run(K128, 2'd0, 7, 45);
    chk("model128_r0", exp_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("model128_r1", exp_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("model128_r10", exp_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("t128_r0", vt[0], 4);
    chk("t128_r10", vt[10], 44);
    run(K192, 2'd1, 20, 53);
    chk("model192_w6", exp_w[6], 32'hfe0c91f7);
    chk("model192_r12", exp_rk[12], 128'he98ba06f448c773c8ecc720401002202);
    chk("t192_r12", vt[12], 52);
    run(K256, 2'd2, 30, 61);
    chk("model256_w8", exp_w[8], 32'h9ba35411);
    chk("model256_r14", exp_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
    chk("t256_r14", vt[14], 60);
    smask = 16'h0409;
    run(K128, 2'd0, 7, 60);
    smask = '0;
    chk("bp_r0", vt[0], 4);
    chk("bp_r3", vt[3], 21);
    chk("bp_r4", vt[4], 30);
    chk("bp_r10", vt[10], 54);
    key_len = 2'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_len3", err, 1);
    chk("err_len3_busy", busy, 0);
    chk("err_len3_valid", rk_valid, 0);
    @(posedge clk); #1;
    chk("err_len3_pulse", err, 0);
    chk("err_len3_idle", busy, 0);
    key_s = K128[255:128];
    key_len_s = 2'd2;
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    chk("err_max128", err_s, 1);
    chk("err_max128_busy", busy_s, 0);
    chk("err_max128_valid", rk_valid_s, 0);
    @(posedge clk); #1;
    chk("err_max128_pulse", err_s, 0);
    chk("err_max128_idle", busy_s, 0);
    prep(K128, 2'd0);
    key = K128;
    key_len = 2'd0;
    start = 1'b1;
    @(posedge clk); #1;
    e0 = edge_no;
    start = 1'b0;
    n = 0;
    while (!(rk_valid && round_idx == 4'd4) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("round4_cycle", n, 20);
    chk_en = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_round_key", round_key, 0);
    chk("abort_round_idx", round_idx, 0);
    chk("abort_rk_valid", rk_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_err", err, 0);
    run(K128, 2'd0, 3, 45);
    chk("rerun_r10", vt[10], 44);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
